// File: rtl/seq_chunk_addsub_if.sv
// -----------------------------------------------------------------------------
// seq_chunk_addsub_if
// Start/done bus between a requester (master) and the sequential
// adder/subtractor (slave).
//   start     : request, master -> slave
//   sub       : 0 = add with carry_in, 1 = subtract
//   x, y      : operands, latched by the slave on an accepted start
//   carry_in  : carry into bit 0 for additions
//   sum       : registered result, valid when done pulses
//   carry_out : carry out of the MSB (for subtract: 1 = no borrow)
//   busy      : high while the slave is computing
//   done      : one-cycle pulse when sum/carry_out are final
//   overflow  : signed overflow, present only with SEQ_ADDSUB_OVERFLOW_EN
// -----------------------------------------------------------------------------
interface seq_chunk_addsub_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
  logic             done;
`ifdef SEQ_ADDSUB_OVERFLOW_EN
  logic             overflow;

  modport master (output start, sub, x, y, carry_in,
                  input  sum, carry_out, busy, done, overflow);
  modport slave  (input  start, sub, x, y, carry_in,
                  output sum, carry_out, busy, done, overflow);
`else
  modport master (output start, sub, x, y, carry_in,
                  input  sum, carry_out, busy, done);
  modport slave  (input  start, sub, x, y, carry_in,
                  output sum, carry_out, busy, done);
`endif
endinterface

// File: rtl/seq_chunk_addsub.sv
// -----------------------------------------------------------------------------
// seq_chunk_addsub
// Multi-cycle adder/subtractor. Operands are latched on an accepted start and
// the result is produced CHUNK bits per clock, LSB chunk first, with the carry
// registered between chunks. Only a CHUNK-bit ripple sits in any one cycle.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (discards any operation in flight)
//   bus : seq_chunk_addsub_if.slave (start/sub/x/y/carry_in in,
//         sum/carry_out/busy/done[/overflow] out)
//
// Parameters:
//   WIDTH : operand/result width, a multiple of CHUNK
//   CHUNK : bits added per clock; NCHUNK = WIDTH/CHUNK
//
// Optional feature macro: SEQ_ADDSUB_OVERFLOW_EN adds a registered signed
// overflow flag, updated together with carry_out.
// -----------------------------------------------------------------------------
module seq_chunk_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                clk,
  input  logic                rst,
  seq_chunk_addsub_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;      // already inverted for subtraction
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              busy_q;
  logic              done_q;
`ifdef SEQ_ADDSUB_OVERFLOW_EN
  logic              ovf_q;
`endif

  // Slice the latched operands into chunks so the active one is a plain mux.
  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_d;  // {carry, CHUNK-bit sum} of the active chunk

  assign a_chunk = a_chunks[idx_q];
  assign b_chunk = b_chunks[idx_q];
  assign chunk_d = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADDSUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE accepts start exactly like IDLE so operations can run back to back.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.x;
            b_q     <= bus.sub ? ~bus.y : bus.y;
            carry_q <= bus.sub ? 1'b1 : bus.carry_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
          carry_q <= chunk_d[CHUNK];
          if (idx_q == LAST_IDX) begin
            cout_q  <= chunk_d[CHUNK];
`ifdef SEQ_ADDSUB_OVERFLOW_EN
            // The last chunk holds the MSB, so its sum bit is the result sign.
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (chunk_d[CHUNK-1] != a_q[WIDTH-1]);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef SEQ_ADDSUB_OVERFLOW_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_addsub
// Drives three instances (CHUNK = 16, 64, 8 at WIDTH = 64) with shared
// operands and compares every result, latency and busy length against a
// plain-arithmetic reference model. Directed tests cover reset, carry
// propagation, subtraction, back-to-back starts, start during RUN, operand
// changes during RUN and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_seq_chunk_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_r = 1'b0;
  logic        glitch_r = 1'b0;
  logic        sub_r = 1'b0;
  logic        cin_r = 1'b0;
  logic [63:0] x_r = '0;
  logic [63:0] y_r = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_chunk_addsub_if #(.WIDTH(64)) if16 ();
  seq_chunk_addsub_if #(.WIDTH(64)) if64 ();
  seq_chunk_addsub_if #(.WIDTH(64)) if8  ();

  // Only the CHUNK=16 instance sees the extra mid-RUN start pulse.
  assign if16.start = start_r | glitch_r;
  assign if64.start = start_r;
  assign if8.start  = start_r;
  assign if16.sub = sub_r;   assign if64.sub = sub_r;   assign if8.sub = sub_r;
  assign if16.x = x_r;       assign if64.x = x_r;       assign if8.x = x_r;
  assign if16.y = y_r;       assign if64.y = y_r;       assign if8.y = y_r;
  assign if16.carry_in = cin_r;
  assign if64.carry_in = cin_r;
  assign if8.carry_in  = cin_r;

  seq_chunk_addsub #(.WIDTH(64), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  seq_chunk_addsub #(.WIDTH(64), .CHUNK(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));
  seq_chunk_addsub #(.WIDTH(64), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

  logic [63:0] sum_w  [3];
  logic        cout_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  assign sum_w[0] = if16.sum;  assign sum_w[1] = if64.sum;  assign sum_w[2] = if8.sum;
  assign cout_w[0] = if16.carry_out; assign cout_w[1] = if64.carry_out; assign cout_w[2] = if8.carry_out;
  assign busy_w[0] = if16.busy; assign busy_w[1] = if64.busy; assign busy_w[2] = if8.busy;
  assign done_w[0] = if16.done; assign done_w[1] = if64.done; assign done_w[2] = if8.done;
`ifdef SEQ_ADDSUB_OVERFLOW_EN
  logic ovf_w [3];
  assign ovf_w[0] = if16.overflow; assign ovf_w[1] = if64.overflow; assign ovf_w[2] = if8.overflow;
`endif

  // NCHUNK of each instance = edges from the start-sampling edge to done.
  int lat_exp [3] = '{4, 1, 8};

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: exact 65-bit sum of A + B + cin with B inverted for subtract.
  function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic c);
    logic [63:0] bb;
    bb = s ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 65'(s ? 1'b1 : c);
  endfunction

  function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b, input logic s,
                                   input logic c);
    logic [63:0] bb;
    logic [64:0] r;
    bb = s ? ~b : b;
    r  = ref_sum(a, b, s, c);
    return (a[63] == bb[63]) && (r[63] != a[63]);
  endfunction

  // One operation on all instances; operands are scrambled after the start
  // edge so the latched values are what gets checked.
  task automatic do_op(input logic [63:0] ax, input logic [63:0] ay,
                       input logic asub, input logic acin, input logic pulse);
    logic [64:0] want;
    logic        want_ovf;
    int          seen [3];
    int          bcnt [3];
    want     = ref_sum(ax, ay, asub, acin);
    want_ovf = ref_ovf(ax, ay, asub, acin);
    $display("op x=%h y=%h sub=%b cin=%b expect=%h ovf=%b", ax, ay, asub, acin, want, want_ovf);
    for (int i = 0; i < 3; i++) begin
      seen[i] = -1;
      bcnt[i] = 0;
    end
    x_r = ax; y_r = ay; sub_r = asub; cin_r = acin; start_r = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start_r = 1'b0;
        x_r = {$urandom, $urandom}; y_r = {$urandom, $urandom};
        sub_r = 1'($urandom); cin_r = 1'($urandom);
      end
      glitch_r = pulse && (k == 1);
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bcnt[i]++;
        if (done_w[i]) begin
          if (seen[i] >= 0) begin
            check($sformatf("done_twice[%0d]", i), 65'd1, 65'd0);
          end else begin
            seen[i] = k;
            check($sformatf("latency[%0d]", i), 65'(k), 65'(lat_exp[i]));
            check($sformatf("result[%0d]", i), {cout_w[i], sum_w[i]}, want);
`ifdef SEQ_ADDSUB_OVERFLOW_EN
            check($sformatf("overflow[%0d]", i), 65'(ovf_w[i]), 65'(want_ovf));
`endif
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (seen[i] < 0) check($sformatf("done_timeout[%0d]", i), 65'd0, 65'd1);
      check($sformatf("busy_cycles[%0d]", i), 65'(bcnt[i]), 65'(lat_exp[i]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    int ndone;
    logic [64:0] want;

    // 1. Reset state and first operation.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_sum[%0d]", i), {cout_w[i], sum_w[i]}, 65'd0);
      check($sformatf("rst_ctl[%0d]", i), {63'd0, busy_w[i], done_w[i]}, 65'd0);
    end
    do_op(64'd420000021, 64'd500009800, 1'b0, 1'b0, 1'b0);
    check("t1_sum", {cout_w[0], sum_w[0]}, {1'b0, 64'd920009821});

    // 2. Carry across every chunk boundary.
    do_op('1, 64'd1, 1'b0, 1'b1, 1'b0);
    check("t2_wrap", {cout_w[0], sum_w[0]}, {1'b1, 64'd1});
    do_op('1, '1, 1'b0, 1'b1, 1'b0);
    check("t2_ones", {cout_w[0], sum_w[0]}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

    // 3. Subtraction (carry_in ignored).
    do_op(64'd10, 64'd3, 1'b1, 1'b1, 1'b0);
    check("t3_sub", {cout_w[0], sum_w[0]}, {1'b1, 64'd7});
`ifdef SEQ_ADDSUB_OVERFLOW_EN
    check("t3_ovf_a", 65'(ovf_w[0]), 65'd0);
`endif
    do_op(64'd3, 64'd10, 1'b1, 1'b0, 1'b0);
    check("t3_borrow", {cout_w[0], sum_w[0]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFF9});
`ifdef SEQ_ADDSUB_OVERFLOW_EN
    check("t3_ovf_b", 65'(ovf_w[0]), 65'd0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b1, 1'b0, 1'b0);
    check("t3_ovf_c", 65'(ovf_w[0]), 65'd1);
`endif

    // 4a. start held high: done every 5th cycle on the CHUNK=16 instance.
    x_r = 64'h0123_4567_89AB_CDEF; y_r = 64'hFEDC_BA98_7654_3210; sub_r = 1'b0; cin_r = 1'b1;
    want = ref_sum(x_r, y_r, 1'b0, 1'b1);
    start_r = 1'b1;
    prev = -1;
    ndone = 0;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin
        ndone++;
        check("b2b_result", {cout_w[0], sum_w[0]}, want);
        if (prev >= 0) check("b2b_spacing", 65'(k - prev), 65'd5);
        prev = k;
      end
    end
    check("b2b_count", 65'(ndone), 65'd4);
    start_r = 1'b0;
    idle(20);

    // 4b/4c. Operands change during RUN (always) and start pulsed during RUN.
    do_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b1);

    // 5. Reset in the second RUN cycle.
    x_r = '1; y_r = '1; sub_r = 1'b0; cin_r = 1'b0; start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_sum", {cout_w[0], sum_w[0]}, 65'd0);
    check("midrst_ctl", {63'd0, busy_w[0], done_w[0]}, 65'd0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (done_w[i] || busy_w[i]) ndone++;
    end
    check("midrst_quiet", 65'(ndone), 65'd0);
    do_op(64'd12500002, 64'd31030099, 1'b0, 1'b1, 1'b0);
    check("t5_sum", {cout_w[0], sum_w[0]}, {1'b0, 64'd43530102});

    // 6. Random operations on all three chunkings.
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] rx;
      logic [63:0] ry;
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rx = '1;
      if ($urandom_range(0, 7) == 0) ry = ($urandom_range(0, 1) == 0) ? '1 : '0;
      do_op(rx, ry, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_addsub.md
Name: seq_chunk_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the fixed-width 64-bit ripple-carry adder.
- Operands are latched on a start handshake.
- The result is computed CHUNK bits per clock, LSB chunk first, with the carry registered between chunks.
- It trades latency for a short critical path: one CHUNK-bit ripple per cycle instead of WIDTH bits.
- It is used by datapath blocks that accept variable-latency arithmetic via start/done.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per clock cycle; NCHUNK = WIDTH/CHUNK; NCHUNK >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0: x+y+carry_in; 1: x-y (x + ~y + 1, carry_in ignored); latched with start.
- x  input  WIDTH  operand A; latched with start.
- y  input  WIDTH  operand B; latched with start.
- carry_in  input  1  carry into bit 0 when sub=0; latched with start.
- sum  output  WIDTH  result, registered; held stable from done until next accepted start.
- carry_out  output  1  carry out of MSB (for sub: 1 = no borrow); registered; held like sum.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when sum/carry_out are final.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sum=0, carry_out=0, busy=0, done=0, chunk index=0. This applies from any state, including mid-RUN. Any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch x, sub, carry_in; latch y as ~y if sub=1, else y. Initial carry = sub ? 1 : carry_in. Chunk index=0. Go to RUN. sum is not cleared on start.
- RUN, each edge: add chunk[idx] of the latched A and B with the registered carry. Write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK] and register the chunk carry.
  - If idx==NCHUNK-1: set carry_out to the final carry and go to DONE.
  - Otherwise: idx+1.
- RUN ignores start; inputs x/y/sub/carry_in may change freely without effect.
- DONE: done=1 for exactly this one cycle, busy=0.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operations with no idle gap. Go to RUN.
  - Otherwise go to IDLE.
- Latency: done is high in the cycle following the NCHUNK-th edge after the edge that sampled start. Throughput is one operation per NCHUNK+1 cycles back-to-back.
- Arithmetic: unsigned modulo 2^WIDTH. {carry_out,sum} equals the exact (WIDTH+1)-bit sum of A+B+cin.
- NCHUNK=1: RUN lasts one cycle; behaviour is otherwise identical.
- Partial sum bits during RUN are not meaningful to consumers and must be qualified by done.

Optional Feature:
- Macro: SEQ_ADDSUB_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), registered with carry_out.
  - overflow = (A[WIDTH-1]==B[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]), where B is the post-inversion operand: two's-complement signed overflow.
  - Reset 0; held like sum.
- Not defined: no overflow port, and no logic for it.

Test Plan:
All scenarios use WIDTH=64, CHUNK=16.
1. rst held 2 cycles, then released -> sum=0, carry_out=0, busy=0, done=0. start with x=420000021, y=500009800, carry_in=0, sub=0 -> busy for 4 cycles, then done pulse for 1 cycle with sum=920009821, carry_out=0.
2. Carry across chunk boundaries: x=64'hFFFFFFFFFFFFFFFF, y=1, carry_in=1 -> sum=1, carry_out=1. Then x=y=64'hFFFF..FF, carry_in=1 -> sum=64'hFFFF..FF, carry_out=1.
3. Subtract: x=10, y=3, sub=1, carry_in=1 -> sum=7, carry_out=1. Then x=3, y=10 -> sum=64'hFFFFFFFFFFFFFFF9, carry_out=0. With macro: overflow=0 for both; x=64'h7FFF..FF, y=64'hFFFF..FF, sub=1 -> overflow=1.
4. Handshake:
   - start held high throughout -> back-to-back operations, done every 5th cycle.
   - x changed during RUN -> result uses the latched value.
   - start pulsed during RUN -> ignored.
5. Reset mid-op: rst=1 in the 2nd RUN cycle -> next cycle IDLE, sum=0, busy=0, no done pulse. A following operation x=12500002, y=31030099, carry_in=1 -> sum=43530102.
6. Parameter sweep, CHUNK=64 (NCHUNK=1) and CHUNK=8 (NCHUNK=8): random 1000 operations against a reference model -> exact {carry_out,sum}; done latency of 1 and 8 cycles respectively.
